// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for inter-stage pipeline registers
package pipe_pkg;

    // Stage occupancy state; encoding doubles as the held-entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_e;

    // Default bundle widths for the EX/MEM boundary.
    localparam int CTRL_W_EM = 4;
    localparam int DATA_W_EM = 101;

    // EX/MEM control bundle: {RegWrite, ResultSrc[1:0], MemWrite}
    localparam int EM_MEMWRITE_BIT   = 0;
    localparam int EM_RESULTSRC_LSB  = 1;
    localparam int EM_RESULTSRC_W    = 2;
    localparam int EM_REGWRITE_BIT   = 3;

    // EX/MEM data bundle: {ALUResult, WriteData, Rd, PCPlus4}
    localparam int EM_XLEN           = 32;
    localparam int EM_RD_W           = 5;
    localparam int EM_PCPLUS4_LSB    = 0;
    localparam int EM_RD_LSB         = EM_PCPLUS4_LSB + EM_XLEN;
    localparam int EM_WDATA_LSB      = EM_RD_LSB + EM_RD_W;
    localparam int EM_ALU_LSB        = EM_WDATA_LSB + EM_XLEN;

    // Build an EX/MEM control bundle from its named fields.
    function automatic logic [CTRL_W_EM-1:0] pack_exmem_ctrl(
        input logic       reg_write,
        input logic [1:0] result_src,
        input logic       mem_write
    );
        return {reg_write, result_src, mem_write};
    endfunction

    // Build an EX/MEM data bundle from its named fields.
    function automatic logic [DATA_W_EM-1:0] pack_exmem_data(
        input logic [EM_XLEN-1:0] alu_result,
        input logic [EM_XLEN-1:0] write_data,
        input logic [EM_RD_W-1:0] rd,
        input logic [EM_XLEN-1:0] pc_plus4
    );
        return {alu_result, write_data, rd, pc_plus4};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// rtl/pipe_stage_reg_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Clear beats increment; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with 2-entry skid buffer, flush and stall counter
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W            = CTRL_W_EM,
    parameter int DATA_W            = DATA_W_EM,
    parameter bit FLUSH_CLEARS_DATA = 1'b0,
    parameter int CNT_W             = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    state_e             r_state;
    state_e             w_next_state;
    logic               r_in_ready;
    logic [CTRL_W-1:0]  r_main_ctrl;
    logic [DATA_W-1:0]  r_main_data;
    logic [CTRL_W-1:0]  r_skid_ctrl;
    logic [DATA_W-1:0]  r_skid_data;

    logic               w_out_valid;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_load_main_in;
    logic               w_load_main_skid;
    logic               w_load_skid;
    logic               w_stall_inc;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = in_valid && r_in_ready;
    assign w_out_fire  = w_out_valid && out_ready;

    // State register; reset lands in EMPTY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and entry-load decode; flush overrides every handshake.
    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_next_state   = ST_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_next_state = ST_TWO;
                    w_load_skid  = 1'b1;
                end else if (w_out_fire) begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only the output side can move.
                if (w_out_fire) begin
                    w_next_state     = ST_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_EMPTY;
            end
        endcase
        if (flush) begin
            w_next_state     = ST_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    // in_ready is a flop fed from next state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_next_state != ST_TWO);
        end
    end

    // Main entry: loads from input or promotes skid; flush turns it into a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
        end else if (flush) begin
            r_main_ctrl <= '0;
            if (FLUSH_CLEARS_DATA) begin
                r_main_data <= '0;
            end
        end else if (w_load_main_in) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
        end else if (w_load_main_skid) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
        end
    end

    // Skid entry: catches the input that arrives while the main entry is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_skid_ctrl <= '0;
            if (FLUSH_CLEARS_DATA) begin
                r_skid_data <= '0;
            end
        end else if (w_load_skid) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
        end
    end

    // A stall cycle is a held valid output that downstream refuses, outside a flush.
    assign w_stall_inc = w_out_valid && !out_ready && !flush;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_stall_inc),
        .clr (stall_clr),
        .q   (stall_cnt)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    // Bubbles carry zero control so downstream enables need no separate valid gate.
    assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;
    assign occupancy = r_state;

endmodule
